// File: rtl/spi_frame_master.sv
// Write-only SPI mode-0 master that sends one 7-byte frame:
// cmd, addr, data, each byte LSB first, from a start/busy/done handshake.
module spi_frame_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [15:0] addr,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        cs,
    output logic        sck,
    output logic        mosi
);

    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);
    localparam logic [5:0] N_BITS   = 6'd56;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        HOLD
    } state_t;

    state_t      state, state_d;
    logic [55:0] sr, sr_d;
    logic [5:0]  bit_cnt, bit_cnt_d;
    logic [7:0]  cnt, cnt_d;
    logic        cnt_zero;
    logic        cs_d, sck_d, mosi_d, busy_d, done_d;

    assign cnt_zero = (cnt == 8'd0);

    always_comb begin
        state_d   = state;
        sr_d      = sr;
        bit_cnt_d = bit_cnt;
        cnt_d     = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d   = SETUP;
                    sr_d      = {data, addr, cmd};
                    bit_cnt_d = 6'd0;
                    cnt_d     = SETUP_M1;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = SHIFT_LO;
                    cnt_d   = DIV_M1;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            SHIFT_LO: begin
                if (cnt_zero) begin
                    state_d = SHIFT_HI;
                    cnt_d   = DIV_M1;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            SHIFT_HI: begin
                if (cnt_zero) begin
                    bit_cnt_d = bit_cnt + 6'd1;
                    if (bit_cnt_d == N_BITS) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_M1;
                    end else begin
                        state_d = SHIFT_LO;
                        sr_d    = {1'b0, sr[55:1]};
                        cnt_d   = DIV_M1;
                    end
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // outputs are registered from the next state so they align with it
        cs_d   = (state_d == IDLE);
        sck_d  = (state_d == SHIFT_HI);
        busy_d = (state_d != IDLE);
        done_d = (state == HOLD) && (state_d == IDLE);
        mosi_d = 1'b0;
        if (state_d == SETUP || state_d == SHIFT_LO || state_d == SHIFT_HI) begin
            mosi_d = sr_d[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            cnt     <= '0;
            cs      <= 1'b1;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            sr      <= sr_d;
            bit_cnt <= bit_cnt_d;
            cnt     <= cnt_d;
            cs      <= cs_d;
            sck     <= sck_d;
            mosi    <= mosi_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: instance 0 runs CLK_DIV/CS_SETUP/CS_HOLD=2,
// instance 1 runs all three at 1; a timeline model checks every cycle.
module tb_spi_frame_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start_i = 2'b00;
    logic [7:0]  cmd_i  [2];
    logic [15:0] addr_i [2];
    logic [31:0] data_i [2];
    logic [1:0]  busy_o, done_o, cs_o, sck_o, mosi_o;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    spi_frame_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_i[0]),
        .cmd(cmd_i[0]), .addr(addr_i[0]), .data(data_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .cs(cs_o[0]),
        .sck(sck_o[0]), .mosi(mosi_o[0])
    );

    spi_frame_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_i[1]),
        .cmd(cmd_i[1]), .addr(addr_i[1]), .data(data_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .cs(cs_o[1]),
        .sck(sck_o[1]), .mosi(mosi_o[1])
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // {cs, sck, mosi, busy, done} at cycle k of a frame accepted in cycle 0
    function automatic logic [4:0] exp_out(input int k, input bit act,
                                           input int su, input int d,
                                           input int ho, input logic [55:0] f);
        int t, r, i;
        t = 1 + su + 112 * d + ho;
        if (!act) return 5'b10000;
        if (k == t) return 5'b10001;
        r = k - 1 - su;
        if (r < 0) return {2'b00, f[0], 2'b10};
        if (r >= 112 * d) return 5'b00010;
        i = r / (2 * d);
        return {1'b0, ((r % (2 * d)) >= d), f[i], 2'b10};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int D = (g == 0) ? 2 : 1;
        localparam int T = 1 + D + 112 * D + D;
        bit act = 1'b0;
        int k = 0;
        logic [55:0] f = '0;
        int busy_n = 0, cslo = 0, viol = 0, rn = 0, first = -1, last_done = -1;
        logic psck = 1'b0, pmosi = 1'b0, pcs = 1'b1;
        logic [55:0] rx = '0;
        int rxn = 0;
        logic [55:0] rxq[$];
        int riseq[$];
        int firstq[$];

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                act = 1'b0;
            end else if ((!act || k == T) && start_i[g]) begin
                act = 1'b1;
                k = 1;
                f = {data_i[g], addr_i[g], cmd_i[g]};
            end else if (act) begin
                if (k == T) act = 1'b0;
                else k++;
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                chk($sformatf("outputs_%0d", g),
                    {cs_o[g], sck_o[g], mosi_o[g], busy_o[g], done_o[g]},
                    exp_out(k, act, D, D, D, f));
                if (!cs_o[g] && pcs) begin
                    rn = 0;
                    first = -1;
                end
                if (sck_o[g] && !psck) begin
                    rn++;
                    if (first < 0) first = cyc;
                end
                if (busy_o[g]) busy_n++;
                if (!cs_o[g]) cslo++;
                if (sck_o[g] && mosi_o[g] !== pmosi) viol++;
                if (done_o[g]) begin
                    last_done = cyc;
                    rxq.push_back(rx);
                    riseq.push_back(rn);
                    firstq.push_back(first);
                end
                psck = sck_o[g];
                pmosi = mosi_o[g];
                pcs = cs_o[g];
            end
        end

        // behavioural slave: sample mosi on each sck rise while selected
        always @(negedge cs_o[g]) rxn = 0;
        always @(posedge sck_o[g]) begin
            if (!cs_o[g] && rxn < 56) begin
                rx[rxn] = mosi_o[g];
                rxn++;
            end
        end
    end

    task automatic launch(input int i, input logic [7:0] c,
                          input logic [15:0] a, input logic [31:0] d,
                          output int t0);
        @(posedge clk);
        #1;
        cmd_i[i] = c;
        addr_i[i] = a;
        data_i[i] = d;
        start_i[i] = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start_i[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int limit);
        bit got;
        got = 1'b0;
        for (int n = 0; n < limit && !got; n++) begin
            @(negedge clk);
            if (done_o[i]) got = 1'b1;
        end
        chk("done_timeout", {63'd0, got}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, n0, busy0, cslo0, viol0;
        logic [55:0] fr;
        logic [7:0] eb [7];
        for (int i = 0; i < 2; i++) begin
            cmd_i[i] = '0;
            addr_i[i] = '0;
            data_i[i] = '0;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_cs", {63'd0, cs_o[i]}, 64'd1);
            chk("reset_sck", {63'd0, sck_o[i]}, 64'd0);
            chk("reset_mosi", {63'd0, mosi_o[i]}, 64'd0);
            chk("reset_busy", {63'd0, busy_o[i]}, 64'd0);
            chk("reset_done", {63'd0, done_o[i]}, 64'd0);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // basic frame
        n0 = mon[0].rxq.size();
        busy0 = mon[0].busy_n;
        launch(0, 8'hA5, 16'h1234, 32'hDEADBEEF, t0);
        wait_done(0, 400);
        fr = mon[0].rxq[$];
        eb = '{8'hA5, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int j = 0; j < 7; j++) chk("basic_byte", 64'(fr[8*j +: 8]), 64'(eb[j]));
        chk("basic_rises", 64'(mon[0].riseq[$]), 64'd56);
        chk("basic_first_rise", 64'(mon[0].firstq[$] - t0), 64'd5);
        chk("basic_done_cycle", 64'(mon[0].last_done - t0), 64'd229);
        chk("basic_done_count", 64'(mon[0].rxq.size() - n0), 64'd1);
        chk("basic_busy_cycles", 64'(mon[0].busy_n - busy0), 64'd228);

        // loopback reassembly
        cslo0 = mon[0].cslo;
        launch(0, 8'h3C, 16'hBEEF, 32'h01234567, t0);
        wait_done(0, 400);
        fr = mon[0].rxq[$];
        chk("loop_cmd", 64'(fr[7:0]), 64'h3C);
        chk("loop_addr", 64'(fr[23:8]), 64'hBEEF);
        chk("loop_data", 64'(fr[55:24]), 64'h01234567);
        chk("loop_cs_low", 64'(mon[0].cslo - cslo0), 64'd228);

        // start while busy
        n0 = mon[0].rxq.size();
        cslo0 = mon[0].cslo;
        launch(0, 8'h11, 16'h2222, 32'h33333333, t0);
        while (cyc < t0 + 50) begin
            @(posedge clk);
            #1;
        end
        cmd_i[0] = 8'h99;
        addr_i[0] = 16'h8888;
        data_i[0] = 32'h77777777;
        start_i[0] = 1'b1;
        @(posedge clk);
        #1;
        start_i[0] = 1'b0;
        wait_done(0, 400);
        repeat (20) @(posedge clk);
        #1;
        chk("busy_start_frame", mon[0].rxq[$], {32'h33333333, 16'h2222, 8'h11});
        chk("busy_start_dones", 64'(mon[0].rxq.size() - n0), 64'd1);
        chk("busy_start_cs_low", 64'(mon[0].cslo - cslo0), 64'd228);

        // back-to-back with start held high
        n0 = mon[0].rxq.size();
        cslo0 = mon[0].cslo;
        @(posedge clk);
        #1;
        cmd_i[0] = 8'h81;
        addr_i[0] = 16'h4002;
        data_i[0] = 32'h80000001;
        start_i[0] = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        cmd_i[0] = 8'h7E;
        addr_i[0] = 16'h0FF0;
        data_i[0] = 32'hCAFEF00D;
        wait_done(0, 400);
        start_i[0] = 1'b0;
        wait_done(0, 400);
        chk("b2b_dones", 64'(mon[0].rxq.size() - n0), 64'd2);
        chk("b2b_done_cycle", 64'(mon[0].last_done - t0), 64'd458);
        chk("b2b_cs_low", 64'(mon[0].cslo - cslo0), 64'd456);
        chk("b2b_frame1", mon[0].rxq[n0], {32'h80000001, 16'h4002, 8'h81});
        chk("b2b_frame2", mon[0].rxq[n0+1], {32'hCAFEF00D, 16'h0FF0, 8'h7E});

        // asynchronous reset mid-frame, while sck is high
        n0 = mon[0].rxq.size();
        launch(0, 8'hC3, 16'h5AA5, 32'h12345679, t0);
        while (cyc < t0 + 101) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_sck", {63'd0, sck_o[0]}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_cs", {63'd0, cs_o[0]}, 64'd1);
        chk("abort_sck", {63'd0, sck_o[0]}, 64'd0);
        chk("abort_mosi", {63'd0, mosi_o[0]}, 64'd0);
        chk("abort_busy", {63'd0, busy_o[0]}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(mon[0].rxq.size() - n0), 64'd0);
        launch(0, 8'h5A, 16'hC3C3, 32'h0F1E2D3C, t0);
        wait_done(0, 400);
        chk("after_reset_frame", mon[0].rxq[$], {32'h0F1E2D3C, 16'hC3C3, 8'h5A});
        chk("after_reset_done", 64'(mon[0].last_done - t0), 64'd229);

        // CLK_DIV=1 instance
        n0 = mon[1].rxq.size();
        viol0 = mon[1].viol;
        launch(1, 8'hFF, 16'h0000, 32'hFFFFFFFF, t0);
        wait_done(1, 200);
        chk("div1_done_cycle", 64'(mon[1].last_done - t0), 64'd115);
        chk("div1_first_rise", 64'(mon[1].firstq[$] - t0), 64'd3);
        chk("div1_rises", 64'(mon[1].riseq[$]), 64'd56);
        chk("div1_frame", mon[1].rxq[$], 64'h00FFFFFFFF0000FF);
        chk("div1_mosi_stable", 64'(mon[1].viol - viol0), 64'd0);
        chk("div1_dones", 64'(mon[1].rxq.size() - n0), 64'd1);
        chk("div2_mosi_stable", 64'(mon[0].viol), 64'd0);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
